checkpoint_table: RTL and testbench

Allocates, holds and retires branch checkpoints for the out-of-order core. Dispatch requests a checkpoint for each branch, recording the branch's active-list index. Branch resolution either frees that checkpoint or triggers a rollback. A rollback produces the new active-list front and a mask of every younger checkpoint to squash. Ordering is tracked with an internal age matrix, so no active-list position comparison is needed.

---
 rtl/checkpoint_table_pkg.sv | 15 +
 rtl/checkpoint_table_if.sv | 35 +++
 rtl/checkpoint_table_lowest_free_encoder.sv | 23 ++
 rtl/checkpoint_table.sv | 134 +++++++++++++
 tb/tb_checkpoint_table.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/checkpoint_table_pkg.sv
// Shared types and constants for the branch checkpoint table.
// The guarded define lets this file compile even when riscv_core.svh is not on the include path.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package checkpoint_table_pkg;

  localparam int CKPT_DEPTH = 8;
  localparam int AL_W       = $clog2(`AL_SIZE);

  typedef logic [$clog2(CKPT_DEPTH)-1:0] ckpt_id_t;
  typedef logic [AL_W-1:0]               al_idx_t;

endpackage

// File: rtl/checkpoint_table_if.sv
// Dispatch, resolve and rollback signals between the core and the checkpoint table.
interface checkpoint_table_if
  import checkpoint_table_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH
);

  localparam int ID_W  = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alloc_req;
  logic [AL_W-1:0]   alloc_al_idx;
  logic              alloc_gnt;
  logic [ID_W-1:0]   alloc_id;
  logic              full;
  logic              res_valid;
  logic [ID_W-1:0]   res_id;
  logic              res_mispredict;
  logic              flush_all;
  logic              rollback_valid;
  logic [AL_W-1:0]   rollback_front;
  logic [DEPTH-1:0]  flush_mask;
  logic [CNT_W-1:0]  free_count;

  modport master (
    output alloc_req, alloc_al_idx, res_valid, res_id, res_mispredict, flush_all,
    input  alloc_gnt, alloc_id, full, rollback_valid, rollback_front, flush_mask, free_count
  );

  modport slave (
    input  alloc_req, alloc_al_idx, res_valid, res_id, res_mispredict, flush_all,
    output alloc_gnt, alloc_id, full, rollback_valid, rollback_front, flush_mask, free_count
  );

endinterface

// File: rtl/checkpoint_table_lowest_free_encoder.sv
// Priority encoder returning the lowest set bit of the free vector.
module lowest_free_encoder #(
  parameter int DEPTH = 8,
  localparam int ID_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] free,
  output logic [ID_W-1:0]  index,
  output logic             any
);

  always_comb begin
    index = '0;
    any   = 1'b0;
    // Scan downward so the lowest free entry is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free[i]) begin
        index = ID_W'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/checkpoint_table.sv
// Branch checkpoint table: allocates checkpoints, frees them on correct resolve,
// and computes the squash set and new active-list front on a mispredict.
module checkpoint_table
  import checkpoint_table_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH
) (
  input logic               clk,
  input logic               reset,
  checkpoint_table_if.slave bus
);

  localparam int ID_W  = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [AL_W-1:0]  al_idx_q [DEPTH];

  logic             rb_valid_q, rb_valid_d;
  logic [AL_W-1:0]  rb_front_q, rb_front_d;
  logic [DEPTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] free_q, free_d;

  logic [ID_W-1:0]  low_id;
  logic             any_free;
  logic             res_hit;
  logic             mis_act;
  logic             res_ok;
  logic [DEPTH-1:0] squash;

  lowest_free_encoder #(.DEPTH(DEPTH)) u_enc (
    .free  (~valid_q),
    .index (low_id),
    .any   (any_free)
  );

  assign res_hit = bus.res_valid && valid_q[bus.res_id];
  assign mis_act = res_hit && bus.res_mispredict;
  assign res_ok  = res_hit && !bus.res_mispredict;

  assign bus.full      = !any_free;
  assign bus.alloc_id  = low_id;
  assign bus.alloc_gnt = bus.alloc_req && any_free && !mis_act && !bus.flush_all && !reset;

  // Younger entries record the mispredicting entry as older than themselves.
  always_comb begin
    squash = '0;
    for (int j = 0; j < DEPTH; j++) begin
      squash[j] = valid_q[j] && older_q[j][bus.res_id];
    end
    squash[bus.res_id] = 1'b1;
  end

  always_comb begin
    valid_d    = valid_q;
    older_d    = older_q;
    rb_valid_d = 1'b0;
    rb_front_d = rb_front_q;
    mask_d     = '0;

    if (bus.flush_all) begin
      valid_d = '0;
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end else if (mis_act) begin
      valid_d = valid_q & ~squash;
      for (int i = 0; i < DEPTH; i++) begin
        older_d[i] = squash[i] ? '0 : (older_q[i] & ~squash);
      end
      rb_valid_d = 1'b1;
      rb_front_d = al_idx_q[bus.res_id] + 1'b1;
      mask_d     = squash;
    end else begin
      if (bus.alloc_gnt) begin
        valid_d[low_id] = 1'b1;
        for (int i = 0; i < DEPTH; i++) older_d[i][low_id] = 1'b0;
        older_d[low_id]         = valid_q;
        older_d[low_id][low_id] = 1'b0;
      end
      // Applied after the alloc so a same-cycle allocation forgets the freed entry.
      if (res_ok) begin
        valid_d[bus.res_id] = 1'b0;
        for (int i = 0; i < DEPTH; i++) older_d[i][bus.res_id] = 1'b0;
      end
    end
  end

  always_comb begin
    free_d = CNT_W'(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_d[i]) free_d = free_d - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      rb_valid_q <= 1'b0;
      rb_front_q <= '0;
      mask_q     <= '0;
      free_q     <= CNT_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        older_q[i]  <= '0;
        al_idx_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      rb_valid_q <= rb_valid_d;
      rb_front_q <= rb_front_d;
      mask_q     <= mask_d;
      free_q     <= free_d;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
      if (bus.alloc_gnt) al_idx_q[low_id] <= bus.alloc_al_idx;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.alloc_req && !any_free))
        else $warning("checkpoint_table: alloc_req while full");
      assert (!(bus.res_valid && !valid_q[bus.res_id]))
        else $warning("checkpoint_table: resolve of invalid id %0d", bus.res_id);
    end
  end
`endif

  assign bus.rollback_valid = rb_valid_q;
  assign bus.rollback_front = rb_front_q;
  assign bus.flush_mask     = mask_q;
  assign bus.free_count     = free_q;

endmodule

// File: tb/tb_checkpoint_table.sv
// Directed self-checking bench for checkpoint_table.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module tb_checkpoint_table;
  import checkpoint_table_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  checkpoint_table_if #(.DEPTH(8)) bus ();

  checkpoint_table #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_req      = 1'b0;
    bus.alloc_al_idx   = '0;
    bus.res_valid      = 1'b0;
    bus.res_id         = '0;
    bus.res_mispredict = 1'b0;
    bus.flush_all      = 1'b0;
  endtask

  task automatic do_alloc(input int al, input int exp_id, input string tag);
    bus.alloc_req    = 1'b1;
    bus.alloc_al_idx = AL_W'(al);
    #1;
    chk({tag, "_gnt"}, 32'(bus.alloc_gnt), 32'd1);
    chk({tag, "_id"}, 32'(bus.alloc_id), 32'(exp_id));
    tick();
    bus.alloc_req = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush_all = 1'b1;
    tick();
    bus.flush_all = 1'b0;
  endtask

  task automatic resolve(input int id, input logic mis);
    bus.res_valid      = 1'b1;
    bus.res_id         = 3'(id);
    bus.res_mispredict = mis;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    bus.alloc_req = 1'b1;
    #1;
    chk("gnt_in_reset", 32'(bus.alloc_gnt), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_free", 32'(bus.free_count), 32'd8);
    chk("rst_rbv", 32'(bus.rollback_valid), 32'd0);
    chk("rst_front", 32'(bus.rollback_front), 32'd0);
    chk("rst_mask", 32'(bus.flush_mask), 32'd0);

    // Fill all eight entries.
    for (int i = 0; i < 8; i++) do_alloc(3 + i, i, "fill");
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_free", 32'(bus.free_count), 32'd0);
    bus.alloc_req = 1'b1;
    #1;
    chk("ninth_gnt", 32'(bus.alloc_gnt), 32'd0);
    tick();
    idle();
    do_flush();
    chk("flush_free", 32'(bus.free_count), 32'd8);
    chk("flush_full", 32'(bus.full), 32'd0);

    // Mispredict squashes the resolving entry and all younger ones.
    do_alloc(10, 0, "a2");
    do_alloc(12, 1, "a2");
    do_alloc(14, 2, "a2");
    do_alloc(16, 3, "a2");
    resolve(1, 1'b1);
    tick();
    idle();
    chk("mis_rbv", 32'(bus.rollback_valid), 32'd1);
    chk("mis_front", 32'(bus.rollback_front), 32'd13);
    chk("mis_mask", 32'(bus.flush_mask), 32'h0e);
    chk("mis_free", 32'(bus.free_count), 32'd7);
    tick();
    chk("pulse_end_rbv", 32'(bus.rollback_valid), 32'd0);
    chk("pulse_end_mask", 32'(bus.flush_mask), 32'd0);
    chk("pulse_end_front", 32'(bus.rollback_front), 32'd13);
    do_flush();

    // Front wraps around the active list.
    do_alloc(`AL_SIZE - 1, 0, "wrap");
    resolve(0, 1'b1);
    tick();
    idle();
    chk("wrap_rbv", 32'(bus.rollback_valid), 32'd1);
    chk("wrap_front", 32'(bus.rollback_front), 32'd0);
    chk("wrap_mask", 32'(bus.flush_mask), 32'h01);
    chk("wrap_free", 32'(bus.free_count), 32'd8);
    tick();

    // Same-cycle correct resolve and alloc: freed entry is not re-granted.
    do_alloc(1, 0, "a3");
    do_alloc(2, 1, "a3");
    do_alloc(3, 2, "a3");
    resolve(0, 1'b0);
    bus.alloc_req    = 1'b1;
    bus.alloc_al_idx = AL_W'(4);
    #1;
    chk("same_gnt", 32'(bus.alloc_gnt), 32'd1);
    chk("same_id", 32'(bus.alloc_id), 32'd3);
    tick();
    idle();
    chk("same_free", 32'(bus.free_count), 32'd5);
    resolve(1, 1'b1);
    tick();
    idle();
    chk("a3_mask", 32'(bus.flush_mask), 32'h0e);
    chk("a3_front", 32'(bus.rollback_front), 32'd3);
    chk("a3_free", 32'(bus.free_count), 32'd8);
    tick();

    // Mispredict blocks a same-cycle allocation.
    do_alloc(5, 0, "a4");
    do_alloc(6, 1, "a4");
    resolve(0, 1'b1);
    bus.alloc_req = 1'b1;
    #1;
    chk("mis_blocks_gnt", 32'(bus.alloc_gnt), 32'd0);
    tick();
    idle();
    chk("a4_mask", 32'(bus.flush_mask), 32'h03);
    chk("a4_free", 32'(bus.free_count), 32'd8);
    tick();

    // flush_all overrides a mispredict.
    do_alloc(8, 0, "a5");
    do_alloc(9, 1, "a5");
    resolve(0, 1'b1);
    bus.flush_all = 1'b1;
    tick();
    idle();
    chk("fl_mis_rbv", 32'(bus.rollback_valid), 32'd0);
    chk("fl_mis_mask", 32'(bus.flush_mask), 32'd0);
    chk("fl_mis_free", 32'(bus.free_count), 32'd8);
    chk("fl_mis_full", 32'(bus.full), 32'd0);

    // Reset during the rollback pulse clears it.
    do_alloc(7, 0, "a6");
    resolve(0, 1'b1);
    tick();
    idle();
    chk("a6_rbv", 32'(bus.rollback_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_mid_rbv", 32'(bus.rollback_valid), 32'd0);
    chk("rst_mid_mask", 32'(bus.flush_mask), 32'd0);
    chk("rst_mid_front", 32'(bus.rollback_front), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_free", 32'(bus.free_count), 32'd8);
    do_alloc(11, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
